// File: rtl/lfsr_stim_gen_if.sv
// Handshake and status bundle for the LFSR stimulus generator.
// master: the consumer/controller side; slave: the generator itself.
interface lfsr_stim_gen_if;
  logic        enable;
  logic        load_seed;
  logic [15:0] seed;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  a;
  logic [3:0]  b;
  logic [3:0]  c;
  logic [15:0] gen_count;
  logic [7:0]  clamp_count;

  modport master (
    output enable,
    output load_seed,
    output seed,
    output out_ready,
    input  out_valid,
    input  a,
    input  b,
    input  c,
    input  gen_count,
    input  clamp_count
  );

  modport slave (
    input  enable,
    input  load_seed,
    input  seed,
    input  out_ready,
    output out_valid,
    output a,
    output b,
    output c,
    output gen_count,
    output clamp_count
  );
endinterface

// File: rtl/lfsr_stim_gen.sv
// LFSR-driven constrained stimulus generator with a valid/ready output.
// A 16-bit Galois LFSR advances once per word load; each word is carved from
// the new LFSR value and optionally has its c field pulled into range.
module lfsr_stim_gen #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter bit          CONSTRAIN = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  lfsr_stim_gen_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  localparam logic [15:0] Taps = 16'hB400;

  state_e      state_q;
  logic [15:0] lfsr_q;
  logic [3:0]  a_q, b_q, c_q;
  logic [15:0] gen_count_q;
  logic [7:0]  clamp_count_q;

  logic [15:0] lfsr_next;
  logic [3:0]  word_a, word_b, word_c_raw, word_c;
  logic        clamp_hit;
  logic        transfer;
  logic        seed_load;
  logic        word_load;

  // Next LFSR value and the word derived from it.
  always_comb begin
    lfsr_next  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? Taps : 16'h0000);
    word_a     = lfsr_next[3:0];
    word_b     = lfsr_next[7:4];
    word_c_raw = lfsr_next[11:8];
    // Large a or b with c in 10..15 is out of range; fold c down into 4..9.
    clamp_hit  = CONSTRAIN && ((word_a > 4'd5) || (word_b > 4'd5)) && (word_c_raw > 4'd9);
    word_c     = clamp_hit ? (word_c_raw - 4'd6) : word_c_raw;
  end

  // Handshake decode: a seed load in IDLE takes priority over starting generation.
  always_comb begin
    transfer  = (state_q == StActive) && bus.out_ready;
    seed_load = (state_q == StIdle) && bus.load_seed;
    word_load = ((state_q == StIdle) && !bus.load_seed && bus.enable) ||
                (transfer && bus.enable);
  end

  // Control FSM: IDLE waits for enable, ACTIVE holds the word until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!bus.load_seed && bus.enable) begin
            state_q <= StActive;
          end
        end
        StActive: begin
          if (transfer && !bus.enable) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // LFSR state: reseed in IDLE (zero seed mapped to SEED), advance per word load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (seed_load) begin
      lfsr_q <= (bus.seed == 16'h0000) ? SEED : bus.seed;
    end else if (word_load) begin
      lfsr_q <= lfsr_next;
    end
  end

  // Output word registers; they keep their last value when returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 4'd0;
      b_q <= 4'd0;
      c_q <= 4'd0;
    end else if (word_load) begin
      a_q <= word_a;
      b_q <= word_b;
      c_q <= word_c;
    end
  end

  // Transfer counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_count_q <= 16'd0;
    end else if (transfer) begin
      gen_count_q <= gen_count_q + 16'd1;
    end
  end

  // Count of clamped words, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clamp_count_q <= 8'd0;
    end else if (word_load && clamp_hit && (clamp_count_q != 8'hFF)) begin
      clamp_count_q <= clamp_count_q + 8'd1;
    end
  end

  assign bus.out_valid   = (state_q == StActive);
  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.c           = c_q;
  assign bus.gen_count   = gen_count_q;
  assign bus.clamp_count = clamp_count_q;

  // A presented word stays put until it is accepted.
  a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable({bus.a, bus.b, bus.c})));

  // Constrained words never pair a large a or b with c above 9.
  a_c_range: assert property (@(posedge clk) disable iff (!rst_n)
    !(CONSTRAIN && bus.out_valid && ((bus.a > 4'd5) || (bus.b > 4'd5))) || (bus.c <= 4'd9));

endmodule

// File: tb/tb_lfsr_stim_gen.sv
// Self-checking bench for lfsr_stim_gen: directed tables, hand-written corner
// sequences and a long randomized run against a behavioural model.
module tb_lfsr_stim_gen;

  localparam int unsigned SeedP = 16'hACE1;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load_seed;
  logic [15:0] seed;
  logic        out_ready;

  int n_tests;
  int n_fail;

  lfsr_stim_gen_if bus1 ();
  lfsr_stim_gen_if bus0 ();

  assign bus1.enable    = enable;
  assign bus1.load_seed = load_seed;
  assign bus1.seed      = seed;
  assign bus1.out_ready = out_ready;
  assign bus0.enable    = enable;
  assign bus0.load_seed = load_seed;
  assign bus0.seed      = seed;
  assign bus0.out_ready = out_ready;

  lfsr_stim_gen #(.SEED(16'hACE1), .CONSTRAIN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  lfsr_stim_gen #(.SEED(16'hACE1), .CONSTRAIN(1'b0)) dut_raw (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (constrained instance), plain integers.
  int unsigned m_lfsr, m_a, m_b, m_c, m_gen, m_clamp;
  bit          m_valid;

  function automatic int unsigned lfsr_adv(input int unsigned l);
    return (l / 2) ^ ((l % 2 == 1) ? 32'hB400 : 32'h0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr  = SeedP;
    m_valid = 1'b0;
    m_a = 0; m_b = 0; m_c = 0;
    m_gen = 0; m_clamp = 0;
  endtask

  task automatic model_load_word();
    int unsigned n, cr;
    n = lfsr_adv(m_lfsr);
    m_lfsr = n;
    m_a = n % 16;
    m_b = (n / 16) % 16;
    cr  = (n / 256) % 16;
    if ((m_a > 5 || m_b > 5) && cr > 9) begin
      m_c = cr - 6;
      if (m_clamp < 255) m_clamp++;
    end else begin
      m_c = cr;
    end
    m_valid = 1'b1;
  endtask

  // One clock of the specified behaviour, using the inputs the DUT sampled.
  task automatic model_step();
    if (!m_valid) begin
      if (load_seed) m_lfsr = (seed == 16'h0) ? SeedP : int'(seed);
      else if (enable) model_load_word();
    end else if (out_ready) begin
      m_gen = (m_gen + 1) % 65536;
      if (enable) model_load_word();
      else m_valid = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("valid", bus1.out_valid, m_valid);
    chk("a", bus1.a, m_a);
    chk("b", bus1.b, m_b);
    chk("c", bus1.c, m_c);
    chk("gen_count", bus1.gen_count, m_gen);
    chk("clamp_count", bus1.clamp_count, m_clamp);
    if (bus1.out_valid === 1'b1 && (bus1.a > 4'd5 || bus1.b > 4'd5))
      chk("c_range_guarantee", bus1.c <= 4'd9, 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic [15:0] seed;
    bit          same_cycle;
    int unsigned a, b, c, c_raw, clamped;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int unsigned first_a, first_b, first_c;
    int unsigned cb;
    logic [3:0] sa, sb, sc;
    logic [15:0] sg;
    int guard;
    bit wrapped;

    n_tests = 0;
    n_fail  = 0;

    tbl[0] = '{seed: 16'h140E, same_cycle: 1'b0, a: 7, b: 0,  c: 4,  c_raw: 10, clamped: 1};
    tbl[1] = '{seed: 16'h1404, same_cycle: 1'b1, a: 2, b: 0,  c: 10, c_raw: 10, clamped: 0};
    tbl[2] = '{seed: 16'h0000, same_cycle: 1'b0, a: 0, b: 7,  c: 2,  c_raw: 2,  clamped: 0};
    tbl[3] = '{seed: 16'h0001, same_cycle: 1'b1, a: 0, b: 0,  c: 4,  c_raw: 4,  clamped: 0};
    tbl[4] = '{seed: 16'h1F60, same_cycle: 1'b0, a: 0, b: 11, c: 9,  c_raw: 15, clamped: 1};

    rst_n = 1'b0; enable = 1'b0; load_seed = 1'b0; seed = 16'h0; out_ready = 1'b0;
    model_reset();
    #12;
    chk("reset_valid", bus1.out_valid, 0);
    chk("reset_abc", {bus1.a, bus1.b, bus1.c}, 0);
    chk("reset_gen", bus1.gen_count, 0);
    chk("reset_clamp", bus1.clamp_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous enable/ready after reset: valid one cycle later, no bubbles.
    enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stream_valid", bus1.out_valid, 1);
      if (i == 0) begin
        first_a = m_a; first_b = m_b; first_c = m_c;
      end
    end
    chk("stream_gen4", bus1.gen_count, 4);
    enable = 1'b0;
    cycle();
    chk("drain_idle", bus1.out_valid, 0);

    // Seed-load table; some rows also assert enable with the load.
    foreach (tbl[i]) begin
      out_ready = 1'b0;
      load_seed = 1'b1; seed = tbl[i].seed; enable = tbl[i].same_cycle;
      cycle();
      chk("seed_wins", bus1.out_valid, 0);
      load_seed = 1'b0; enable = 1'b1;
      cb = bus1.clamp_count;
      cycle();
      enable = 1'b0;
      chk("tbl_a", bus1.a, tbl[i].a);
      chk("tbl_b", bus1.b, tbl[i].b);
      chk("tbl_c", bus1.c, tbl[i].c);
      chk("tbl_raw_a", bus0.a, tbl[i].a);
      chk("tbl_raw_c", bus0.c, tbl[i].c_raw);
      chk("tbl_clamp_delta", bus1.clamp_count, cb + tbl[i].clamped);
      if (tbl[i].seed == 16'h0) chk("zero_seed_first", {bus1.a, bus1.b, bus1.c},
                                    {first_a[3:0], first_b[3:0], first_c[3:0]});
      out_ready = 1'b1;
      cycle();
    end

    // Stall while ACTIVE with noisy controls: everything holds.
    enable = 1'b1; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    sa = bus1.a; sb = bus1.b; sc = bus1.c; sg = bus1.gen_count;
    for (int i = 0; i < 6; i++) begin
      enable = i[0]; load_seed = i[1]; seed = 16'($urandom);
      cycle();
      chk("stall_valid", bus1.out_valid, 1);
      chk("stall_abc", {bus1.a, bus1.b, bus1.c}, {sa, sb, sc});
      chk("stall_gen", bus1.gen_count, sg);
    end
    load_seed = 1'b0; enable = 1'b0; out_ready = 1'b1;
    cycle();

    // Reset mid-stream discards the pending word and restarts from SEED.
    enable = 1'b1; out_ready = 1'b1;
    cycle(); cycle(); cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_valid", bus1.out_valid, 0);
    chk("midrst_abc", {bus1.a, bus1.b, bus1.c}, 0);
    chk("midrst_gen", bus1.gen_count, 0);
    chk("midrst_clamp", bus1.clamp_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("midrst_first", {bus1.a, bus1.b, bus1.c}, {first_a[3:0], first_b[3:0], first_c[3:0]});

    // Randomized traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      enable    = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      load_seed = ($urandom % 8) == 0;
      seed      = (($urandom % 16) == 0) ? 16'h0 : 16'($urandom);
      cycle();
    end
    chk("clamp_saturated", bus1.clamp_count, 255);

    // Long back-to-back run until the transfer counter wraps.
    enable = 1'b1; out_ready = 1'b1; load_seed = 1'b0;
    wrapped = 1'b0;
    guard = 0;
    while (!wrapped && guard < 70000) begin
      cycle();
      guard++;
      if (m_gen == 0) begin
        wrapped = 1'b1;
        chk("gen_wrap_zero", bus1.gen_count, 0);
      end
    end
    if (!wrapped) chk("gen_wrap_timeout", 0, 1);
    cycle();
    chk("gen_after_wrap", bus1.gen_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
